// File: rtl/lvds_tx_scheduler_pkg.sv
// lvds_tx_pkg: shared state encoding, frame constants and frame builder for the LVDS transmit scheduler
package lvds_tx_pkg;
    typedef enum logic [1:0] {IDLE, PREPARE, TRANSMIT, END} state_t;
    localparam logic [1:0] SYNC_HI = 2'b10;
    localparam logic [1:0] SYNC_LO = 2'b01;
    localparam logic [12:0] CW_VAL = 13'h0FFF;
    localparam logic [31:0] MARKER_WORD = {SYNC_HI, 14'b0, SYNC_LO, 14'b0};
    function automatic logic [31:0] build_frame(input logic [12:0] i, input logic [12:0] q);
        return {SYNC_HI, i, 1'b1, SYNC_LO, q, 1'b0};
    endfunction
endpackage

// File: rtl/lvds_tx_scheduler_if.sv
// lvds_tx_scheduler_if: slot, control, generator and status signals of the transmit scheduler
interface lvds_tx_scheduler_if #(parameter int SAMPLE_W = 13);
    logic i_slot, i_transmit, i_abort, i_reg_cw;
    logic o_gen_enable, i_gen_valid, i_gen_last;
    logic [SAMPLE_W-1:0] i_gen_i, i_gen_q;
    logic [31:0] o_tx_data;
    logic o_busy, o_msg_done, o_overflow;
    logic [7:0] o_underrun_cnt;
    modport master (
        output i_slot, i_transmit, i_abort, i_reg_cw, i_gen_valid, i_gen_last, i_gen_i, i_gen_q,
        input o_gen_enable, o_tx_data, o_busy, o_msg_done, o_overflow, o_underrun_cnt
    );
    modport slave (
        input i_slot, i_transmit, i_abort, i_reg_cw, i_gen_valid, i_gen_last, i_gen_i, i_gen_q,
        output o_gen_enable, o_tx_data, o_busy, o_msg_done, o_overflow, o_underrun_cnt
    );
endinterface

// File: rtl/lvds_tx_scheduler_sample_buf.sv
// tx_sample_buf: one-entry sample holding register; a write while full is dropped and flagged sticky
module tx_sample_buf #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic         full,
    output logic [W-1:0] dout,
    output logic         overflow
);
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            dout <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr && full) overflow <= 1'b1;
            if (wr && !full) begin
                dout <= din;
                full <= 1'b1;
            end else if (rd) full <= 1'b0;
        end
    end
endmodule

// File: rtl/lvds_tx_scheduler.sv
// lvds_tx_scheduler: per word-slot choice of idle, I/Q data or end marker for the LVDS transmitter
module lvds_tx_scheduler
    import lvds_tx_pkg::*;
#(
    parameter int SAMPLE_W = 13,
    parameter int PREP_SLOTS = 4
) (
    input logic clk,
    input logic reset,
    lvds_tx_scheduler_if.slave bus
);
    state_t state;
    logic [3:0] cnt;
    logic slot_d, tx_d, start_pend, abort_pend, last_seen;
    logic slot_pe, buf_full, buf_last, buf_rd;
    logic [SAMPLE_W-1:0] buf_i, buf_q;
    logic [31:0] data_word;
    assign slot_pe = bus.i_slot && !slot_d;
    assign bus.o_busy = state != IDLE;
    assign buf_rd = slot_pe && state == PREPARE && !abort_pend && cnt == 4'(PREP_SLOTS - 1) && buf_full;
    assign data_word = bus.i_reg_cw ? build_frame(CW_VAL, CW_VAL) : build_frame(buf_i, buf_q);
    tx_sample_buf #(.W(2 * SAMPLE_W + 1)) u_buf (
        .clk(clk),
        .reset(reset),
        .wr(bus.i_gen_valid),
        .din({bus.i_gen_last, bus.i_gen_i, bus.i_gen_q}),
        .rd(buf_rd),
        .full(buf_full),
        .dout({buf_last, buf_i, buf_q}),
        .overflow(bus.o_overflow)
    );
    // Latches run every cycle; case branches below override them on slot strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            slot_d <= 1'b0;
            tx_d <= 1'b0;
            start_pend <= 1'b0;
            abort_pend <= 1'b0;
            last_seen <= 1'b0;
            bus.o_tx_data <= '0;
            bus.o_gen_enable <= 1'b0;
            bus.o_msg_done <= 1'b0;
            bus.o_underrun_cnt <= '0;
        end else begin
            slot_d <= bus.i_slot;
            tx_d <= bus.i_transmit;
            bus.o_gen_enable <= 1'b0;
            bus.o_msg_done <= 1'b0;
            start_pend <= (start_pend && !(slot_pe && state == IDLE)) || (bus.i_transmit && !tx_d);
            abort_pend <= state != IDLE && (abort_pend || bus.i_abort);
            if (slot_pe) begin
                bus.o_tx_data <= '0;
                unique case (state)
                    IDLE: if (start_pend) begin
                        state <= PREPARE;
                        cnt <= '0;
                        last_seen <= 1'b0;
                        bus.o_gen_enable <= 1'b1;
                    end
                    PREPARE: if (abort_pend) begin
                        bus.o_tx_data <= MARKER_WORD;
                        state <= END;
                        abort_pend <= 1'b0;
                    end else if (cnt != 4'(PREP_SLOTS - 1)) cnt <= cnt + 4'd1;
                    else if (buf_full) begin
                        bus.o_tx_data <= data_word;
                        last_seen <= buf_last;
                        state <= TRANSMIT;
                    end else if (bus.o_underrun_cnt != 8'hFF) bus.o_underrun_cnt <= bus.o_underrun_cnt + 8'd1;
                    TRANSMIT: if (last_seen || abort_pend) begin
                        bus.o_tx_data <= MARKER_WORD;
                        state <= END;
                        abort_pend <= 1'b0;
                    end else begin
                        state <= PREPARE;
                        cnt <= '0;
                        bus.o_gen_enable <= 1'b1;
                    end
                    END: begin
                        state <= IDLE;
                        abort_pend <= 1'b0;
                        bus.o_msg_done <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lvds_tx_scheduler.sv
// tb_lvds_tx_scheduler: directed scenarios with hand-computed frame words for the LVDS transmit scheduler
module tb_lvds_tx_scheduler;
    localparam logic [31:0] MK = 32'h8000_4000;
    localparam logic [31:0] D0 = 32'h8247_48AC;
    localparam logic [31:0] D1 = 32'hBFFF_6000;
    localparam logic [31:0] D2 = 32'h8003_5554;
    localparam logic [31:0] DCW = 32'h9FFF_5FFE;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int gen_dly = 2, gen_burst = 1, gen_cd = 0, gen_n = 0, gen_idx = 0, gen_reqs = 0;
    logic [12:0] smp_i [4];
    logic [12:0] smp_q [4];
    logic smp_last [4];
    lvds_tx_scheduler_if bus ();
    lvds_tx_scheduler #(.SAMPLE_W(13), .PREP_SLOTS(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    // Generator model: answers each sample request with gen_burst strobes after gen_dly cycles
    always @(negedge clk) begin
        bus.i_gen_valid = 1'b0;
        if (reset) begin
            gen_cd = 0; gen_n = 0; gen_idx = 0; gen_reqs = 0;
            bus.i_gen_i = '0; bus.i_gen_q = '0; bus.i_gen_last = 1'b0;
        end else begin
            if (gen_cd > 0) begin
                gen_cd--;
                if (gen_cd == 0) gen_n = gen_burst;
            end
            if (gen_n > 0) begin
                bus.i_gen_valid = 1'b1;
                bus.i_gen_i = smp_i[gen_idx % 4];
                bus.i_gen_q = smp_q[gen_idx % 4];
                bus.i_gen_last = smp_last[gen_idx % 4];
                gen_idx++;
                gen_n--;
            end
            if (bus.o_gen_enable) begin
                gen_cd = gen_dly;
                gen_reqs++;
            end
        end
    end
    task automatic do_reset();
        reset = 1'b1;
        bus.i_slot = 1'b0; bus.i_transmit = 1'b0; bus.i_abort = 1'b0; bus.i_reg_cw = 1'b0;
        gen_dly = 2; gen_burst = 1;
        smp_i = '{13'h0123, 13'h1FFF, 13'h0001, 13'h0000};
        smp_q = '{13'h0456, 13'h1000, 13'h0AAA, 13'h0000};
        smp_last = '{1'b0, 1'b0, 1'b1, 1'b0};
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic start();
        bus.i_transmit = 1'b1;
        @(negedge clk);
        bus.i_transmit = 1'b0;
        @(negedge clk);
    endtask
    task automatic slot(output logic [31:0] w, output logic md);
        bus.i_slot = 1'b1;
        @(negedge clk);
        w = bus.o_tx_data;
        md = bus.o_msg_done;
        bus.i_slot = 1'b0;
        repeat (5) @(negedge clk);
    endtask
    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.o_tx_data, bus.o_gen_enable, bus.o_busy, bus.o_msg_done, bus.o_underrun_cnt, bus.o_overflow} !== 44'h0) begin
            failures++;
            $display("FAIL reset_outputs got tx=%h ge=%b busy=%b md=%b ur=%0d ovf=%b exp all zero", bus.o_tx_data, bus.o_gen_enable, bus.o_busy, bus.o_msg_done, bus.o_underrun_cnt, bus.o_overflow);
        end
    endtask
    task automatic test_normal();
        logic [31:0] w;
        logic md;
        int n_md = 0;
        logic [31:0] e [16];
        e = '{0, 0, 0, D0, 0, 0, 0, 0, D1, 0, 0, 0, 0, D2, MK, 0};
        do_reset();
        start();
        slot(w, md);
        checks++;
        if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL normal_busy got=%b exp=1", bus.o_busy); end
        for (int k = 0; k < 16; k++) begin
            slot(w, md);
            n_md += int'(md);
            checks++;
            if (w !== e[k]) begin failures++; $display("FAIL normal_word[%0d] got=%h exp=%h", k, w, e[k]); end
        end
        checks++;
        if (n_md != 1 || md !== 1'b1) begin failures++; $display("FAIL normal_msg_done got pulses=%0d last=%b exp 1 on final slot", n_md, md); end
        checks++;
        if (bus.o_underrun_cnt !== 8'd0) begin failures++; $display("FAIL normal_underrun got=%0d exp=0", bus.o_underrun_cnt); end
        checks++;
        if (gen_reqs != 3) begin failures++; $display("FAIL normal_gen_requests got=%0d exp=3", gen_reqs); end
        checks++;
        if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL normal_idle_busy got=%b exp=0", bus.o_busy); end
    endtask
    task automatic test_cw();
        logic [31:0] w;
        logic md;
        logic [31:0] e [6];
        e = '{0, 0, 0, DCW, MK, 0};
        do_reset();
        smp_i[0] = 13'h1234; smp_q[0] = 13'h0567; smp_last[0] = 1'b1;
        bus.i_reg_cw = 1'b1;
        start();
        slot(w, md);
        for (int k = 0; k < 6; k++) begin
            slot(w, md);
            checks++;
            if (w !== e[k]) begin failures++; $display("FAIL cw_word[%0d] got=%h exp=%h", k, w, e[k]); end
        end
        checks++;
        if (md !== 1'b1) begin failures++; $display("FAIL cw_msg_done got=%b exp=1", md); end
        bus.i_reg_cw = 1'b0;
    endtask
    task automatic test_underrun();
        logic [31:0] w;
        logic md;
        logic [31:0] e [9];
        e = '{0, 0, 0, 0, 0, 0, D0, MK, 0};
        do_reset();
        smp_last[0] = 1'b1;
        gen_dly = 38;
        start();
        slot(w, md);
        for (int k = 0; k < 9; k++) begin
            slot(w, md);
            checks++;
            if (w !== e[k]) begin failures++; $display("FAIL underrun_word[%0d] got=%h exp=%h", k, w, e[k]); end
        end
        checks++;
        if (bus.o_underrun_cnt !== 8'd3) begin failures++; $display("FAIL underrun_count got=%0d exp=3", bus.o_underrun_cnt); end
    endtask
    task automatic test_abort();
        logic [31:0] w;
        logic md;
        do_reset();
        start();
        slot(w, md);
        slot(w, md);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        slot(w, md);
        checks++;
        if (w !== MK) begin failures++; $display("FAIL abort_marker got=%h exp=%h", w, MK); end
        slot(w, md);
        checks++;
        if (w !== 32'h0 || md !== 1'b1) begin failures++; $display("FAIL abort_end got=%h md=%b exp=0 md=1", w, md); end
        slot(w, md);
        slot(w, md);
        checks++;
        if (gen_reqs != 1 || bus.o_busy !== 1'b0 || w !== 32'h0) begin
            failures++;
            $display("FAIL abort_after got reqs=%0d busy=%b tx=%h exp reqs=1 busy=0 tx=0", gen_reqs, bus.o_busy, w);
        end
    endtask
    task automatic test_overflow();
        logic [31:0] w;
        logic md;
        logic [31:0] e [6];
        e = '{0, 0, 0, D0, MK, 0};
        do_reset();
        smp_last[0] = 1'b1;
        gen_burst = 2;
        start();
        slot(w, md);
        for (int k = 0; k < 6; k++) begin
            slot(w, md);
            checks++;
            if (w !== e[k]) begin failures++; $display("FAIL overflow_word[%0d] got=%h exp=%h", k, w, e[k]); end
        end
        checks++;
        if (bus.o_overflow !== 1'b1) begin failures++; $display("FAIL overflow_flag got=%b exp=1", bus.o_overflow); end
    endtask
    task automatic test_start_latch();
        logic [31:0] w;
        logic md;
        logic [31:0] ea [6];
        logic [31:0] eb [5];
        ea = '{0, 0, 0, D0, MK, 0};
        eb = '{0, 0, D1, MK, 0};
        do_reset();
        smp_last = '{1'b1, 1'b1, 1'b1, 1'b1};
        bus.i_transmit = 1'b1;
        @(negedge clk);
        slot(w, md);
        for (int k = 0; k < 6; k++) begin
            slot(w, md);
            checks++;
            if (w !== ea[k]) begin failures++; $display("FAIL held_word[%0d] got=%h exp=%h", k, w, ea[k]); end
        end
        slot(w, md);
        slot(w, md);
        checks++;
        if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL held_no_restart got busy=%b exp=0", bus.o_busy); end
        bus.i_transmit = 1'b0;
        @(negedge clk);
        start();
        slot(w, md);
        slot(w, md);
        start();
        for (int k = 0; k < 5; k++) begin
            slot(w, md);
            checks++;
            if (w !== eb[k]) begin failures++; $display("FAIL pending_word[%0d] got=%h exp=%h", k, w, eb[k]); end
        end
        slot(w, md);
        checks++;
        if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL pending_serviced got busy=%b exp=1", bus.o_busy); end
    endtask
    task automatic test_reset_mid_message();
        logic [31:0] w;
        logic md;
        do_reset();
        start();
        slot(w, md);
        slot(w, md);
        start();
        slot(w, md);
        slot(w, md);
        slot(w, md);
        checks++;
        if (w !== D0) begin failures++; $display("FAIL restart_data got=%h exp=%h", w, D0); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.o_tx_data, bus.o_gen_enable, bus.o_busy, bus.o_msg_done, bus.o_underrun_cnt, bus.o_overflow} !== 44'h0) begin
            failures++;
            $display("FAIL restart_reset_outputs got tx=%h ge=%b busy=%b md=%b ur=%0d ovf=%b exp all zero", bus.o_tx_data, bus.o_gen_enable, bus.o_busy, bus.o_msg_done, bus.o_underrun_cnt, bus.o_overflow);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            slot(w, md);
            checks++;
            if (w !== 32'h0 || bus.o_busy !== 1'b0) begin failures++; $display("FAIL restart_idle[%0d] got tx=%h busy=%b exp tx=0 busy=0", k, w, bus.o_busy); end
        end
    endtask
    initial begin
        test_reset();
        test_normal();
        test_cw();
        test_underrun();
        test_abort();
        test_overflow();
        test_start_latch();
        test_reset_mid_message();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lvds_tx_scheduler.md
# lvds_tx_scheduler

Frame scheduler for the LVDS transmit path. It sits between the signal generator, the SPI control block and `lvds_trx`. On each word-slot strobe from the serializer it decides which 32-bit word goes out next: idle zero, I/Q data frame, or end-of-message marker. It also requests one generator sample per data frame, buffers that sample, applies the CW override and reports underruns.

## Interface
Parameters:
- `SAMPLE_W`, 13: I/Q sample width; the frame format is fixed to 13.
- `PREP_SLOTS`, 4: word slots spent in PREPARE before each data frame. Range 1..15. The value 4 gives an 800 kHz frame rate.

Ports:
- `clk`  in  1  fabric clock, the `lvds_trx` slow clock.
- `reset`  in  1  synchronous, active-high.
- `i_slot`  in  1  `tx_done` level from `lvds_trx`. Its rising edge is the word-slot strobe.
- `i_transmit`  in  1  start level from control. Only its rising edge is used.
- `i_abort`  in  1  single-cycle pulse; ends the current message.
- `i_reg_cw`  in  1  CW override. Substitutes 13'h0FFF for I and Q.
- `o_gen_enable`  out  1  single-cycle sample request to the generator.
- `i_gen_valid`  in  1  generator sample strobe.
- `i_gen_i`, `i_gen_q`  in  13 each  sample, two's complement.
- `i_gen_last`  in  1  qualifies `i_gen_valid`: this is the final sample.
- `o_tx_data`  out  32  word presented to `lvds_trx`.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_msg_done`  out  1  single-cycle pulse when END completes.
- `o_underrun_cnt`  out  8  saturating count of late samples.
- `o_overflow`  out  1  sticky flag; cleared only by reset.

## Operation
- `slot_pe = i_slot & ~slot_d`. All state and `o_tx_data` updates happen only in `slot_pe` cycles. Sample capture and the start/abort latches run every cycle.
- `start_pend`: set on the rising edge of `i_transmit`; cleared when IDLE consumes it. `abort_pend`: set on `i_abort`; cleared on entry to END or IDLE.
- Sample buffer holds one entry `{last, I, Q}`.
  - Written on `i_gen_valid`.
  - If `i_gen_valid` arrives while the buffer is full: drop the new sample and set `o_overflow`.
  - Emptied when a data frame is built.
- Frame words:
  - DATA = {2'b10, I, 1'b1, 2'b01, Q, 1'b0}.
  - MARKER = {2'b10, 14'b0, 2'b01, 14'b0}.
  - IDLE word = 32'h0.
  - When `i_reg_cw` is high at build time, I = Q = 13'h0FFF. The `last` flag is still taken from the buffer.
- State machine:
  - **IDLE**: drive 0. If `start_pend`: go to PREPARE with cnt = 0, and clear the `last_seen` flag.
  - **PREPARE**: drive 0, cnt += 1.
    - If `abort_pend`: drive MARKER and go to END.
    - Else when cnt == PREP_SLOTS−1 and the buffer is full: drive DATA, `last_seen` ← buffer.last, go to TRANSMIT.
    - Else when cnt == PREP_SLOTS−1 and the buffer is empty: drive 0, increment `o_underrun_cnt` (saturate at 255), hold cnt and retry on the next slot.
  - **TRANSMIT**: on the next slot:
    - If `last_seen` or `abort_pend`: drive MARKER and go to END.
    - Else drive 0 and go to PREPARE with cnt = 0.
  - **END**: on the next slot: drive 0, go to IDLE, pulse `o_msg_done`.
- `o_gen_enable` pulses in the cycle after any transition into PREPARE, unless abort is pending.
- Boundary cases:
  - A `start_pend` raised during a message stays latched and is serviced from IDLE.
  - `i_transmit` held high causes no restart.
  - Abort in IDLE is cleared without effect.

## Timing
- Reset values:
  - `o_tx_data` = 0, `o_gen_enable` = 0, `o_busy` = 0, `o_msg_done` = 0, `o_underrun_cnt` = 0, `o_overflow` = 0.
  - State = IDLE, buffer empty, `slot_d` = 0.
  - Reset mid-message returns to IDLE immediately. No marker is emitted.
- `o_tx_data` and state are registered and change in the cycle after the `slot_pe` cycle.
- `o_msg_done` is registered together with the END→IDLE transition.
- Sample capture: data is usable at a slot strobe if `i_gen_valid` occurred in any earlier cycle. Same-cycle valid and `slot_pe` counts as late: it is an underrun, and the sample is used on the next slot.
- Throughput: one DATA word every PREP_SLOTS+1 slots.

## Structure
- Package `lvds_tx_pkg`:
  - State enum: IDLE, PREPARE, TRANSMIT, END.
  - Constants: SYNC_HI = 2'b10, SYNC_LO = 2'b01, CW_VAL = 13'h0FFF, MARKER_WORD.
  - Function `build_frame(i, q)`.
- Sub-module `tx_sample_buf`: one-entry holding register with full flag and overflow detection.
- The FSM, slot edge detector and counters live in the top module.

## Test plan
- Normal 3-sample message, PREP_SLOTS = 4, samples returned 2 cycles after each `o_gen_enable`. Required `o_tx_data` per slot: 0,0,0,DATA0,0,0,0,0,DATA1,0,0,0,0,DATA2(last),MARKER,0. `o_msg_done` pulses once, `o_underrun_cnt` = 0.
- CW mode: `i_reg_cw` = 1, generator I = 13'h1234. DATA word = {2'b10, 13'h0FFF, 1, 2'b01, 13'h0FFF, 0}.
- Underrun: generator withholds `i_gen_valid` for 3 slots past the due slot. Three extra zero words, `o_underrun_cnt` = 3, then DATA.
- Abort during PREPARE at cnt = 1. Next word = MARKER, then 0 and `o_msg_done`. No further `o_gen_enable`.
- Overflow: two `i_gen_valid` pulses before consumption. `o_overflow` = 1 and the first sample is transmitted.
- `i_transmit` toggled mid-message, then reset asserted during TRANSMIT. All outputs are 0 the cycle after reset; state IDLE; latched start discarded.
